// File: rtl/core_mem_pkg.sv
// core_mem_pkg: encodings shared by the data-memory responder and the load/store unit.
package core_mem_pkg;

  // Access size carried on the memory request.
  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'd0,
    SIZE_HALF    = 2'd1,
    SIZE_WORD    = 2'd2,
    SIZE_ILLEGAL = 2'd3
  } size_e;

  // One-hot responder states.
  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_READ   = 6'b000010;
  localparam logic [5:0] ST_RDWAIT = 6'b000100;
  localparam logic [5:0] ST_MERGE  = 6'b001000;
  localparam logic [5:0] ST_WRITE  = 6'b010000;
  localparam logic [5:0] ST_RESP   = 6'b100000;

  // Accept-edge to ACK-sample-edge latency, in cycles, for each kind of access.
  localparam int unsigned LAT_ERR        = 1;
  localparam int unsigned LAT_STORE_WORD = 2;
  localparam int unsigned LAT_LOAD       = 3;
  localparam int unsigned LAT_STORE_SUB  = 4;

  // True when the size is illegal or the byte offset breaks natural alignment.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/core_dmem_resp_if.sv
// core_dmem_resp_if: request/response bus between the load/store unit and the data memory.
interface core_dmem_resp_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, addr, wdata, we, size, uns, input ack, err, rdata);
  modport slave  (input req, addr, wdata, we, size, uns, output ack, err, rdata);
endinterface

// File: rtl/core_dmem_ram.sv
// core_dmem_ram: single-port synchronous word RAM, one-cycle read latency, no reset.
module core_dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Whole-word write, or registered read of the addressed word.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/core_dmem_resp.sv
// core_dmem_resp: serialised data-memory responder; sub-word stores are read-modify-write.
module core_dmem_resp
  import core_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  core_dmem_resp_if.slave bus
);
  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [5:0]    r_state;
  logic [5:0]    w_next;
  logic [AW+1:0] r_off;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [31:0]   r_merge;
  logic [31:0]   r_rdata;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   w_off_in;
  logic          w_accept;
  logic          w_bad;
  logic          w_ram_en;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_idx;
  logic [31:0]   w_ram_wdata;
  logic [31:0]   w_ram_rdata;

  // Pick the addressed lane out of a word and sign- or zero-extend it.
  function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] res;
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      SIZE_BYTE: res = {{24{~uns & b[7]}}, b};
      SIZE_HALF: res = {{16{~uns & h[15]}}, h};
      default:   res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of a word with right-justified store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] res;
    res = word;
    case (size)
      SIZE_BYTE: begin
        case (off)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          default: res[31:24] = data[7:0];
        endcase
      end
      SIZE_HALF: begin
        if (off[1]) begin
          res[31:16] = data[15:0];
        end else begin
          res[15:0] = data[15:0];
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

  // Request decode: offset from the window base, range and alignment checks.
  always_comb begin
    w_off_in = bus.addr - BASE_ADDR;
    w_accept = (r_state == ST_IDLE) && bus.req;
    w_bad    = ({1'b0, w_off_in} >= SPAN_BYTES) || size_misaligned(bus.size, w_off_in[1:0]);
  end

  // Next-state selection; REQ only matters while idle.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (!bus.req) begin
          w_next = ST_IDLE;
        end else if (w_bad) begin
          w_next = ST_RESP;
        end else if (bus.we && (bus.size == SIZE_WORD)) begin
          w_next = ST_WRITE;
        end else begin
          w_next = ST_READ;
        end
      end
      ST_READ: begin
        if (r_we) begin
          w_next = ST_MERGE;
        end else begin
          w_next = ST_RDWAIT;
        end
      end
      ST_RDWAIT: w_next = ST_RESP;
      ST_MERGE:  w_next = ST_WRITE;
      ST_WRITE:  w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // RAM port controls: read in READ, write in WRITE; word stores bypass the merge register.
  always_comb begin
    w_ram_en  = (r_state == ST_READ) || (r_state == ST_WRITE);
    w_ram_we  = (r_state == ST_WRITE);
    w_ram_idx = r_off[AW+1:2];
    if (r_size == SIZE_WORD) begin
      w_ram_wdata = r_wdata;
    end else begin
      w_ram_wdata = r_merge;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ACK/ERR are registered so they are high exactly during the RESP cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= (w_next == ST_RESP);
      r_err <= (r_state == ST_IDLE) && (w_next == ST_RESP);
    end
  end

  // Capture the request at the accept edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_off   <= '0;
      r_wdata <= 32'h0000_0000;
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
    end else if (w_accept) begin
      r_off   <= w_off_in[AW+1:0];
      r_wdata <= bus.wdata;
      r_we    <= bus.we;
      r_size  <= bus.size;
      r_uns   <= bus.uns;
    end
  end

  // Lane merge for sub-word stores and lane extract for loads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_merge <= 32'h0000_0000;
      r_rdata <= 32'h0000_0000;
    end else begin
      if (r_state == ST_MERGE) begin
        r_merge <= merge_lane(w_ram_rdata, r_wdata, r_off[1:0], r_size);
      end
      if (r_state == ST_RDWAIT) begin
        r_rdata <= extract_lane(w_ram_rdata, r_off[1:0], r_size, r_uns);
      end
    end
  end

  core_dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_core_dmem_resp.sv
// tb_core_dmem_resp: directed and randomized checks of core_dmem_resp against a memory model.
module tb_core_dmem_resp;
  localparam int unsigned DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int unsigned N_RAND = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int ack_seen = 0;
  logic [31:0] mem_m [DEPTH];

  core_dmem_resp_if bus ();

  core_dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ack === 1'b1) ack_seen <= ack_seen + 1;
  end

  // ---------------- reference model ----------------
  function automatic logic m_bad(input logic [1:0] size, input logic [31:0] addr);
    longint unsigned a  = 64'(addr);
    longint unsigned lo = 64'(BASE);
    longint unsigned hi = 64'(BASE) + 64'(DEPTH) * 64'd4;
    if (a < lo || a >= hi) return 1'b1;
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (a % 64'd2) != 64'd0) return 1'b1;
    if (size == 2'd2 && (a % 64'd4) != 64'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_lat(input logic we, input logic [1:0] size, input logic bad);
    if (bad) return 1;
    if (!we) return 3;
    if (size == 2'd2) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    logic [31:0] off = addr - BASE;
    int idx = int'(off / 32'd4);
    int sh  = 8 * int'(off % 32'd4);
    logic [31:0] w = mem_m[idx];
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> sh) & 32'h0000_00FF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (w >> sh) & 32'h0000_FFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void m_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off = addr - BASE;
    int idx = int'(off / 32'd4);
    int sh  = 8 * int'(off % 32'd4);
    logic [31:0] mask = (size == 2'd0) ? 32'h0000_00FF : (size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mem_m[idx] = (mem_m[idx] & ~(mask << sh)) | ((data & mask) << sh);
  endfunction

  // ---------------- driver ----------------
  // Presents one request, reports ACK latency (0 = no ACK within budget) and the response.
  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] rdata);
    bus.req = 1'b1; bus.we = we; bus.size = size; bus.uns = uns;
    bus.addr = addr; bus.wdata = wdata;
    lat = 0; err = 1'bx; rdata = 32'hxxxx_xxxx;
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      if (bus.ack === 1'b1) begin
        lat = k; err = bus.err; rdata = bus.rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat != 0) @(posedge clk);
    bus.req = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.uns = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.ack !== 1'b0) begin n_errors++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_checks++; if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_store_load();
    int lat; logic err; logic [31:0] rd;
    do_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, err, rd);
    n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL sw_lat: got %0d expected 2", lat); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL sw_err: got %b expected 0", err); end
    n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL sw_rdata_hold: got %h expected 00000000", rd); end
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL lw_lat: got %0d expected 3", lat); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL lw_err: got %b expected 0", err); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_store_load();
    int lat; logic err; logic [31:0] rd;
    do_txn(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, lat, err, rd);
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL sb_lat: got %0d expected 4", lat); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL sb_rdata_hold: got %h expected deadbeef", rd); end
    do_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_signed: got %h expected ffffff80", rd); end
    do_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu: got %h expected 00000080", rd); end
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h80AD_BEEF) begin n_errors++; $display("FAIL lw_after_sb: got %h expected 80adbeef", rd); end
    do_txn(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'hFFFF_80AD) begin n_errors++; $display("FAIL lh_upper: got %h expected ffff80ad", rd); end
  endtask

  task automatic test_errors();
    int lat; logic err; logic [31:0] rd;
    do_txn(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL lh_mis_lat: got %0d expected 1", lat); end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL lh_mis_err: got %b expected 1", err); end
    n_checks++; if (rd !== 32'hFFFF_80AD) begin n_errors++; $display("FAIL lh_mis_rdata: got %h expected ffff80ad", rd); end
    do_txn(1'b0, 2'd2, 1'b0, BASE + 32'(DEPTH) * 32'd4, 32'h0, lat, err, rd);
    n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL oor_lat: got %0d expected 1", lat); end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL oor_err: got %b expected 1", err); end
    do_txn(1'b1, 2'd3, 1'b0, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (err !== 1'b1 || lat !== 1) begin n_errors++; $display("FAIL size3: got err=%b lat=%0d expected err=1 lat=1", err, lat); end
    do_txn(1'b1, 2'd2, 1'b0, 32'h12, 32'h0, lat, err, rd);
    n_checks++; if (err !== 1'b1 || lat !== 1) begin n_errors++; $display("FAIL sw_mis: got err=%b lat=%0d expected err=1 lat=1", err, lat); end
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h80AD_BEEF) begin n_errors++; $display("FAIL ram_after_err: got %h expected 80adbeef", rd); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic err; logic [31:0] rd; int snap;
    do_txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, lat, err, rd);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.uns = 1'b0;
    bus.addr = 32'h20; bus.wdata = 32'h0000_00AA;
    snap = ack_seen;
    @(posedge clk); #1;   // accept edge -> READ
    @(posedge clk); #1;   // MERGE
    rst = 1'b1;
    bus.req = 1'b0;
    #1;
    n_checks++; if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL rst_mid_rdata: got %h expected 00000000", bus.rdata); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (ack_seen !== snap) begin n_errors++; $display("FAIL rst_mid_ack: got %0d acks expected 0", ack_seen - snap); end
    @(negedge clk);
    rst = 1'b0;
    do_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h1122_3344 || lat !== 3) begin n_errors++; $display("FAIL rst_mid_ram: got %h lat=%0d expected 11223344 lat=3", rd, lat); end
    do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h80AD_BEEF) begin n_errors++; $display("FAIL rst_keeps_ram: got %h expected 80adbeef", rd); end
  endtask

  task automatic test_req_ignore();
    int lat; logic err; logic [31:0] rd; int snap;
    snap = ack_seen;
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.uns = 1'b0;
    bus.addr = 32'h10; bus.wdata = 32'h0;
    @(posedge clk); #1;   // accepted, READ
    bus.req = 1'b0; bus.we = 1'b1; bus.addr = 32'h20; bus.wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;   // RDWAIT
    bus.req = 1'b1;
    @(posedge clk); #1;   // RESP, REQ still high
    n_checks++; if (bus.ack !== 1'b1) begin n_errors++; $display("FAIL ign_ack: got %b expected 1", bus.ack); end
    n_checks++; if (bus.rdata !== 32'h80AD_BEEF) begin n_errors++; $display("FAIL ign_rdata: got %h expected 80adbeef", bus.rdata); end
    @(posedge clk);
    bus.req = 1'b0;
    #1;
    n_checks++; if (bus.ack !== 1'b0) begin n_errors++; $display("FAIL ign_pulse: got %b expected 0", bus.ack); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (ack_seen - snap !== 1) begin n_errors++; $display("FAIL ign_ack_count: got %0d expected 1", ack_seen - snap); end
    do_txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, err, rd);
    n_checks++; if (rd !== 32'h1122_3344) begin n_errors++; $display("FAIL ign_no_store: got %h expected 11223344", rd); end
  endtask

  task automatic test_random();
    int lat; logic err; logic [31:0] rd; int snap; int elat;
    logic [31:0] exp_rd; logic bad; logic we; logic [1:0] size; logic uns;
    logic [31:0] addr; logic [31:0] wdata; int r;
    for (int i = 0; i < int'(DEPTH); i++) begin
      wdata = $urandom;
      do_txn(1'b1, 2'd2, 1'b0, BASE + 32'(i) * 32'd4, wdata, lat, err, rd);
      mem_m[i] = wdata;
    end
    snap = ack_seen;
    do_txn(1'b0, 2'd2, 1'b0, BASE, 32'h0, lat, err, rd);
    n_checks++; if (rd !== mem_m[0]) begin n_errors++; $display("FAIL rnd_first: got %h expected %h", rd, mem_m[0]); end
    exp_rd = mem_m[0];
    for (int n = 0; n < int'(N_RAND); n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) addr = BASE + 32'(DEPTH) * 32'd4 + $urandom_range(0, 63);
      else if (r == 1) addr = 32'hFFFF_FFC0 + $urandom_range(0, 63);
      else addr = BASE + $urandom_range(0, DEPTH * 4 - 1);
      size = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wdata = $urandom;
      bad = m_bad(size, addr);
      elat = m_lat(we, size, bad);
      if (!bad && !we) exp_rd = m_load(size, uns, addr);
      if (!bad && we) m_store(size, addr, wdata);
      do_txn(we, size, uns, addr, wdata, lat, err, rd);
      n_checks++; if (lat !== elat) begin n_errors++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d (we=%b size=%0d addr=%h)", n, lat, elat, we, size, addr); end
      n_checks++; if (err !== bad) begin n_errors++; $display("FAIL rnd_err[%0d]: got %b expected %b (we=%b size=%0d addr=%h)", n, err, bad, we, size, addr); end
      n_checks++; if (rd !== exp_rd) begin n_errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h (we=%b size=%0d uns=%b addr=%h)", n, rd, exp_rd, we, size, uns, addr); end
    end
    n_checks++; if (ack_seen - snap !== int'(N_RAND) + 1) begin n_errors++; $display("FAIL rnd_ack_count: got %0d expected %0d", ack_seen - snap, N_RAND + 1); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store_load();
    test_errors();
    test_reset_mid_op();
    test_req_ignore();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
